// File: rtl/avalon_pio_capture_in_pkg.sv
// Shared definitions for the Avalon-MM capture-input PIO: register map and bit positions.
package avalon_pio_capture_in_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_POP    = 2'd1,
    REG_MASK   = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  localparam int unsigned REG_W = 32;

  // MASK register bits
  localparam int unsigned MASK_NEMPTY_BIT = 0;
  localparam int unsigned MASK_OVF_BIT    = 1;

  // STATUS register bits (read view and write-command view)
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_FLUSH_BIT = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  // POP read word: entry-valid flag
  localparam int unsigned POP_VALID_BIT = 31;

endpackage

// File: rtl/avalon_pio_capture_in_fifo.sv
// Synchronous show-ahead FIFO for captured input changes, with flush.
// Same-cycle push+pop is accepted when full; flush overrides both.
module pio_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rp_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy; flush returns everything to the reset state.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + AW'(1);
      if (do_pop)  rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/avalon_pio_capture_in.sv
// Avalon-MM input PIO: synchronises in_port, exposes its current value,
// queues every change in a FIFO and raises a maskable level IRQ.
module avalon_pio_capture_in
  import avalon_pio_capture_in_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] prev_q;
  logic              change;

  logic [1:0]        mask_q, mask_d;
  logic              ovf_q, ovf_d;
  logic [REG_W-1:0]  readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              rd, wr;
  reg_addr_e         addr_e;
  logic              fifo_pop, fifo_flush, ovf_clr, ovf_set;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  logic [REG_W-1:0]  data_word, pop_word, mask_word, status_word;
  logic              unused_wdata;

  assign unused_wdata = &{1'b0, writedata};

  assign cur    = sync_q[SYNC_STAGES-1];
  assign change = (cur != prev_q);

  assign rd     = chipselect & read;
  assign wr     = chipselect & write;
  assign addr_e = reg_addr_e'(address);

  assign fifo_pop   = rd & (addr_e == REG_POP);
  assign fifo_flush = wr & (addr_e == REG_STATUS) & writedata[STATUS_FLUSH_BIT];
  assign ovf_clr    = wr & (addr_e == REG_STATUS) & writedata[STATUS_OVF_BIT];
  // A change is lost only if the FIFO stays full this cycle and no flush discards it anyway.
  assign ovf_set    = change & fifo_full & ~fifo_pop & ~fifo_flush;

  // Input synchroniser chain and previous-value register for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= cur;
    end
  end

  pio_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (change),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (cur),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Read words for each register offset.
  always_comb begin
    data_word              = '0;
    data_word[DATA_W-1:0]  = cur;

    pop_word = '0;
    if (!fifo_empty) begin
      pop_word[DATA_W-1:0]    = fifo_head;
      pop_word[POP_VALID_BIT] = 1'b1;
    end

    mask_word                  = '0;
    mask_word[MASK_NEMPTY_BIT] = mask_q[MASK_NEMPTY_BIT];
    mask_word[MASK_OVF_BIT]    = mask_q[MASK_OVF_BIT];

    status_word                                 = '0;
    status_word[STATUS_EMPTY_BIT]               = fifo_empty;
    status_word[STATUS_FULL_BIT]                = fifo_full;
    status_word[STATUS_OVF_BIT]                 = ovf_q;
    status_word[STATUS_COUNT_LSB +: CNT_W]      = fifo_count;
  end

  // Register-file next state: read mux, mask write, sticky overflow and irq.
  always_comb begin
    readdata_d = readdata_q;
    mask_d     = mask_q;
    ovf_d      = ovf_q;

    if (rd) begin
      case (addr_e)
        REG_DATA:   readdata_d = data_word;
        REG_POP:    readdata_d = pop_word;
        REG_MASK:   readdata_d = mask_word;
        REG_STATUS: readdata_d = status_word;
        default:    readdata_d = '0;
      endcase
    end

    if (wr && addr_e == REG_MASK)
      mask_d = {writedata[MASK_OVF_BIT], writedata[MASK_NEMPTY_BIT]};

    // Set has priority over a simultaneous clear.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    irq_d = (mask_q[MASK_NEMPTY_BIT] & ~fifo_empty) | (mask_q[MASK_OVF_BIT] & ovf_q);
  end

  // Register-file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      mask_q     <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      mask_q     <= mask_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
